// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with a bounded hold quantum that owns the select lines of a
// 4:1 mux. Grant, valid and select outputs are all taken straight from flops.
module mux4_rr_arbiter #(
    parameter int QUANTUM = 4,
    parameter int CW      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       sel1,
    output logic       sel0
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(QUANTUM - 1);

    state_t        state_reg, state_next;
    logic [1:0]    own_reg, own_next;
    logic [1:0]    ptr_reg, ptr_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    gnt_reg, gnt_next;

    logic [1:0] cand [4];
    logic [3:0] hit;
    logic [1:0] pick;
    logic [3:0] own_onehot;
    logic       own_req;
    logic       others;
    logic       take;

    // Candidate at offset gi from the priority pointer; lowest offset with a request wins.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign cand[gi] = ptr_reg + 2'(gi);
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        pick = cand[0];
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) begin
                pick = cand[i];
            end
        end
    end

    assign own_onehot = 4'b0001 << own_reg;
    assign own_req    = req[own_reg];
    assign others     = |(req & ~own_onehot);

    always_comb begin
        state_next = state_reg;
        own_next   = own_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        take       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    take = 1'b1;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    if (others) begin
                        take = 1'b1;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end else if (cnt_reg == CNT_MAX && others) begin
                    take = 1'b1;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // own_next is left untouched in IDLE so the mux select does not move.
        if (take) begin
            state_next = GRANT;
            own_next   = pick;
            cnt_next   = '0;
            ptr_next   = pick + 2'd1;
        end
        gnt_next = (state_next == GRANT) ? (4'b0001 << own_next) : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            own_reg   <= 2'd0;
            ptr_reg   <= 2'd0;
            cnt_reg   <= '0;
            gnt_reg   <= 4'b0000;
        end else begin
            state_reg <= state_next;
            own_reg   <= own_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            gnt_reg   <= gnt_next;
        end
    end

    assign gnt   = gnt_reg;
    assign valid = (state_reg == GRANT);
    assign sel1  = own_reg[1];
    assign sel0  = own_reg[0];

endmodule
